fetch_queue: RTL and testbench

Parametrised instruction-fetch front end replacing the single-entry fetch buffer and stall-per-instruction handshake. It issues sequential instruction requests to instruction memory and buffers up to DEPTH fetched words with their addresses. It hands them to the decode stage through a valid/ready interface and flushes on a redirect from branch/jump resolution. It sits between the instruction memory port and decode/regset/imm_gen/alu.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end (fetch_queue, fetch_fifo).
package fetch_pkg;

    localparam int unsigned FETCH_XLEN  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries; pointers wrap naturally, flush empties it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count,
    output fetch_entry_t           head
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: head is only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential requests, DEPTH-entry queue, redirect flush.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned            XLEN      = FETCH_XLEN,
    parameter int unsigned            DEPTH     = 4,
    parameter logic [XLEN-1:0]        RESET_ADR = '0
) (
    input  logic            CLK,
    input  logic            RES,
    output logic            instr_req,
    output logic [XLEN-1:0] instr_adr,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr_read,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_adr
);

    localparam int unsigned      CNT_W   = clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W+1)'(DEPTH);

    fetch_state_t     state;
    fetch_state_t     next_state;
    logic [XLEN-1:0]  pend_adr;
    logic [XLEN-1:0]  next_adr;
    logic [XLEN-1:0]  next_pend;
    logic [XLEN-1:0]  target;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   count_after;
    logic             bypass;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign target = redirect_adr & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
    assign bypass = (state == REQ) && instr_valid && empty && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry.pc    = instr_adr;
    assign push_entry.instr = instr_read;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RES),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .head       (head)
    );

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = instr_adr;
            out_instr = instr_read;
        end else if (!empty) begin
            out_valid = 1'b1;
            out_pc    = head.pc;
            out_instr = head.instr;
        end
    end

    always_comb begin
        next_state  = state;
        next_adr    = instr_adr;
        next_pend   = pend_adr;
        push        = 1'b0;
        pop         = !redirect && !empty && out_ready;
        count_after = '0;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    next_adr   = target;
                    next_state = REQ;
                end else if (!full) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // A coincident response is dropped; otherwise wait it out in DROP.
                    if (instr_valid) begin
                        next_adr = target;
                    end else begin
                        next_pend  = target;
                        next_state = DROP;
                    end
                end else if (instr_valid) begin
                    push        = !(bypass && out_ready);
                    next_adr    = instr_adr + XLEN'(INSTR_BYTES);
                    count_after = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
                    if (count_after >= DEPTH_W) next_state = IDLE;
                end
            end
            DROP: begin
                if (redirect) next_pend = target;
                if (instr_valid) begin
                    next_adr   = redirect ? target : pend_adr;
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= IDLE;
            instr_adr <= RESET_ADR;
            pend_adr  <= '0;
            instr_req <= 1'b0;
        end else begin
            state     <= next_state;
            instr_adr <= next_adr;
            pend_adr  <= next_pend;
            instr_req <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model and a latency-driven memory.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        instr_req;
    logic [31:0] instr_adr;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_read = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_adr = '0;

    fetch_queue #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .RESET_ADR (32'h100)
    ) dut (
        .CLK          (CLK),
        .RES          (RES),
        .instr_req    (instr_req),
        .instr_adr    (instr_adr),
        .instr_valid  (instr_valid),
        .instr_read   (instr_read),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .redirect     (redirect),
        .redirect_adr (redirect_adr)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: fetch mode 0=idle, 1=requesting, 2=discarding a stale request.
    int          m_mode;
    logic [31:0] m_adr;
    logic [31:0] m_pend;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];

    // Memory: one response per request, latency counted in visible-request cycles.
    bit          mem_busy;
    logic [31:0] mem_adr;
    int          mem_wait;
    int          lat_min = 1;
    int          lat_max = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic do_reset();
        RES         = 1'b1;
        redirect    = 1'b0;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RES      = 1'b0;
        m_mode   = 0;
        m_adr    = 32'h100;
        m_pend   = '0;
        q_pc.delete();
        q_in.delete();
        mem_busy = 1'b0;
        mem_wait = 0;
        check("rst_req", instr_req, 32'd0);
        check("rst_adr", instr_adr, 32'h100);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
    endtask

    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] ra);
        bit          iv;
        bit          byp;
        bit          exp_v;
        bit          pop;
        logic [31:0] rd;
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        logic [31:0] tgt;
        int          mode0;
        mode0 = m_mode;
        iv    = 1'b0;
        rd    = '0;
        if (m_mode != 0) begin
            if (!mem_busy || mem_adr != m_adr) begin
                mem_busy = 1'b1;
                mem_adr  = m_adr;
                mem_wait = $urandom_range(lat_max, lat_min) - 1;
            end
            if (mem_wait == 0) begin
                iv = 1'b1;
                rd = instr_of(mem_adr);
            end
        end else begin
            mem_busy = 1'b0;
            if ($urandom_range(3, 0) == 0) begin
                iv = 1'b1;
                rd = $urandom;
            end
        end
        out_ready    = rdy;
        redirect     = rv;
        redirect_adr = ra;
        instr_valid  = iv;
        instr_read   = rd;
        #1;

        byp    = BYP && m_mode == 1 && q_pc.size() == 0 && iv && !rv;
        exp_v  = byp || q_pc.size() > 0;
        exp_pc = byp ? m_adr : (q_pc.size() > 0 ? q_pc[0] : 32'd0);
        exp_in = byp ? rd    : (q_in.size() > 0 ? q_in[0] : 32'd0);
        check("instr_req", instr_req, (m_mode != 0) ? 32'd1 : 32'd0);
        check("instr_adr", instr_adr, m_adr);
        check("out_valid", out_valid, exp_v ? 32'd1 : 32'd0);
        check("out_pc", out_pc, exp_pc);
        check("out_instr", out_instr, exp_in);

        tgt = ra & 32'hFFFF_FFFC;
        pop = exp_v && rdy;
        if (rv) begin
            q_pc.delete();
            q_in.delete();
            if (m_mode == 0 || iv) begin
                m_adr  = tgt;
                m_mode = 1;
            end else begin
                m_pend = tgt;
                m_mode = 2;
            end
        end else if (m_mode == 0) begin
            if (q_pc.size() < DEPTH) m_mode = 1;
            if (pop) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
        end else if (m_mode == 1 && iv) begin
            if (byp) begin
                if (!rdy) begin q_pc.push_back(m_adr); q_in.push_back(rd); end
            end else begin
                if (pop) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
                q_pc.push_back(m_adr);
                q_in.push_back(rd);
            end
            m_adr = m_adr + 32'd4;
            if (q_pc.size() >= DEPTH) m_mode = 0;
        end else if (m_mode == 2 && iv) begin
            m_adr  = m_pend;
            m_mode = 1;
        end else if (pop) begin
            void'(q_pc.pop_front());
            void'(q_in.pop_front());
        end

        if (mode0 != 0) begin
            if (iv) mem_busy = 1'b0;
            else if (mem_wait > 0) mem_wait--;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        // Single-cycle memory, decode always ready: sequential stream with no gaps.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (30) cycle(1'b1, 1'b0, '0);

        // Decode stalled: queue fills, fetch parks at 0x110, then resumes in order.
        do_reset();
        repeat (12) cycle(1'b0, 1'b0, '0);
        check("fill_req", instr_req, 32'd0);
        check("fill_adr", instr_adr, 32'h110);
        check("fill_valid", out_valid, 32'd1);
        check("fill_head", out_pc, 32'h100);
        repeat (20) cycle(1'b1, 1'b0, '0);

        // Redirect to an unaligned target while a slow request is outstanding.
        lat_min = 3; lat_max = 3;
        repeat (4) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h2003);
        check("redir_empty", out_valid, 32'd0);
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h3000);
        cycle(1'b1, 1'b1, 32'h4008);
        repeat (12) cycle(1'b1, 1'b0, '0);

        // Address wrap at the top of the space.
        lat_min = 1; lat_max = 2;
        cycle(1'b1, 1'b1, 32'hFFFF_FFF4);
        repeat (12) cycle(1'b1, 1'b0, '0);

        // Random traffic with stalls, redirects and occasional resets.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                ra = $urandom;
                if ($urandom_range(3, 0) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
                cycle($urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0, ra);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
